// File: rtl/program_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// Header layout: upper half is the IMEM word count, lower half the DMEM word count.
package program_loader_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HEADER = 3'd1,
    LOAD_I = 3'd2,
    LOAD_D = 3'd3,
    DRAIN  = 3'd4,
    RUN    = 3'd5,
    ERROR  = 3'd6
  } loader_state_t;

  localparam int HDR_NI_MSB = 31;
  localparam int HDR_NI_LSB = 16;
  localparam int HDR_ND_MSB = 15;
  localparam int HDR_ND_LSB = 0;

  localparam int WORD_SHIFT = 2;

endpackage

// File: rtl/program_loader_load_counter.sv
// Word-index counter for one memory image: clear, increment, and a flag
// that marks the index of the final word (limit - 1).
module load_counter #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic         last
);

  always_ff @(posedge clk) begin
    if (!arst_n || clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + W'(1);
    end
  end

  // limit is never zero while the owning load state is active
  assign last = (count == limit - W'(1));

endmodule

// File: rtl/program_loader.sv
// Streams a header-prefixed image into IMEM then DMEM through the CPU
// external write ports, then enables the CPU until halted.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int IMEM_DEPTH = 512,
  parameter int DMEM_DEPTH = 1024,
  parameter int DATA_W     = 32
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              start,
  input  logic              halt,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic [31:0]       addr_ext,
  output logic              wen_ext,
  output logic [DATA_W-1:0] wdata_ext,
  output logic              ren_ext,
  output logic [31:0]       addr_ext_2,
  output logic              wen_ext_2,
  output logic [DATA_W-1:0] wdata_ext_2,
  output logic              ren_ext_2,
  output logic              cpu_enable,
  output logic              busy,
  output logic              done,
  output logic              error
);

  // One extra bit so a count equal to the depth is representable.
  localparam int I_W = $clog2(IMEM_DEPTH) + 1;
  localparam int D_W = $clog2(DMEM_DEPTH) + 1;
  localparam logic [15:0] I_LIM = 16'(IMEM_DEPTH);
  localparam logic [15:0] D_LIM = 16'(DMEM_DEPTH);

  loader_state_t state_reg, state_next;
  logic [I_W-1:0] n_i_reg;
  logic [D_W-1:0] n_d_reg;
  logic [I_W-1:0] i_cnt;
  logic [D_W-1:0] d_cnt;
  logic           i_last, d_last;
  logic [15:0]    hdr_ni, hdr_nd;
  logic           fire, cnt_clr, i_inc, d_inc;

  assign hdr_ni  = s_data[HDR_NI_MSB:HDR_NI_LSB];
  assign hdr_nd  = s_data[HDR_ND_MSB:HDR_ND_LSB];
  assign fire    = s_valid && s_ready;
  assign cnt_clr = (state_reg == IDLE) && start;
  assign i_inc   = fire && (state_reg == LOAD_I);
  assign d_inc   = fire && (state_reg == LOAD_D);

  assign ren_ext   = 1'b0;
  assign ren_ext_2 = 1'b0;

  load_counter #(.W(I_W)) u_i_cnt (
    .clk(clk), .arst_n(arst_n), .clr(cnt_clr), .inc(i_inc),
    .limit(n_i_reg), .count(i_cnt), .last(i_last)
  );

  load_counter #(.W(D_W)) u_d_cnt (
    .clk(clk), .arst_n(arst_n), .clr(cnt_clr), .inc(d_inc),
    .limit(n_d_reg), .count(d_cnt), .last(d_last)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:   if (start) state_next = HEADER;
      HEADER: begin
        if (fire) begin
          if (hdr_ni > I_LIM || hdr_nd > D_LIM) state_next = ERROR;
          else if (hdr_ni != 16'd0)             state_next = LOAD_I;
          else if (hdr_nd != 16'd0)             state_next = LOAD_D;
          else                                  state_next = DRAIN;
        end
      end
      LOAD_I: if (fire && i_last) state_next = (n_d_reg != '0) ? LOAD_D : DRAIN;
      LOAD_D: if (fire && d_last) state_next = DRAIN;
      DRAIN:  state_next = RUN;
      RUN:    if (halt) state_next = IDLE;
      ERROR:  state_next = ERROR;
      default: state_next = IDLE;
    endcase
  end

  // Status outputs are decoded from the next state so they are registered
  // yet line up with the state they describe.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_reg   <= IDLE;
      n_i_reg     <= '0;
      n_d_reg     <= '0;
      s_ready     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      cpu_enable  <= 1'b0;
      wen_ext     <= 1'b0;
      wen_ext_2   <= 1'b0;
      addr_ext    <= '0;
      addr_ext_2  <= '0;
      wdata_ext   <= '0;
      wdata_ext_2 <= '0;
    end else begin
      state_reg  <= state_next;
      s_ready    <= state_next inside {HEADER, LOAD_I, LOAD_D};
      busy       <= state_next inside {HEADER, LOAD_I, LOAD_D, DRAIN};
      done       <= (state_next == RUN);
      cpu_enable <= (state_next == RUN);
      error      <= (state_next == ERROR);
      wen_ext    <= i_inc;
      wen_ext_2  <= d_inc;
      if (fire && state_reg == HEADER) begin
        n_i_reg <= hdr_ni[I_W-1:0];
        n_d_reg <= hdr_nd[D_W-1:0];
      end
      if (i_inc) begin
        addr_ext  <= 32'(i_cnt) << WORD_SHIFT;
        wdata_ext <= s_data;
      end
      if (d_inc) begin
        addr_ext_2  <= 32'(d_cnt) << WORD_SHIFT;
        wdata_ext_2 <= s_data;
      end
    end
  end

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time loader that sits directly upstream of the `cpu` top level. It accepts a word stream over a valid/ready handshake and parses a one-word header. It then writes the program image into instruction memory through the CPU's `*_ext` port and the data image into data memory through the `*_ext_2` port. Once both writes are complete it raises `cpu_enable`, which drives the CPU's `enable` input and starts execution.

## Interface
- `IMEM_DEPTH`, 512 — instruction memory depth in words (matches the 9-bit IMEM address).
- `DMEM_DEPTH`, 1024 — data memory depth in words (matches the 10-bit DMEM address).
- `DATA_W`, 32 — word width.
- `clk` in 1 — single clock.
- `arst_n` in 1 — reset, **synchronous, active-low**; sampled on the rising edge of `clk` only.
- `start` in 1 — load request pulse; honoured only in IDLE.
- `halt` in 1 — in RUN, stops the CPU and returns the block to IDLE.
- `s_valid` in 1 — stream word valid.
- `s_ready` out 1 — loader accepts a word this cycle.
- `s_data` in DATA_W — stream word.
- `addr_ext` out 32 — IMEM byte address (word index × 4).
- `wen_ext` out 1 — IMEM write strobe.
- `wdata_ext` out DATA_W — IMEM write data.
- `ren_ext` out 1 — IMEM read enable; tied to 0.
- `addr_ext_2` out 32 — DMEM byte address (word index × 4).
- `wen_ext_2` out 1 — DMEM write strobe.
- `wdata_ext_2` out DATA_W — DMEM write data.
- `ren_ext_2` out 1 — DMEM read enable; tied to 0.
- `cpu_enable` out 1 — drives CPU `enable`.
- `busy` out 1 — high in HEADER, LOAD_I, LOAD_D and DRAIN.
- `done` out 1 — high in RUN.
- `error` out 1 — high in ERROR.

## Operation
- **States:** IDLE, HEADER, LOAD_I, LOAD_D, DRAIN, RUN, ERROR.
- **Handshake:** a transfer occurs when `s_valid && s_ready`. `s_ready` is 1 only in HEADER, LOAD_I and LOAD_D.
- **IDLE:** `start`=1 moves to HEADER.
- **HEADER:** one word is accepted.
  - `n_i = s_data[31:16]`, `n_d = s_data[15:0]`.
  - If `n_i > IMEM_DEPTH` or `n_d > DMEM_DEPTH`, go to ERROR.
  - Otherwise go to LOAD_I if `n_i != 0`, else LOAD_D if `n_d != 0`, else DRAIN.
- **LOAD_I:**
  - Each transfer writes IMEM at index `i_cnt`, then increments `i_cnt` (starts at 0).
  - After the transfer with `i_cnt == n_i-1`, go to LOAD_D if `n_d != 0`, else DRAIN.
- **LOAD_D:**
  - Same as LOAD_I using `d_cnt` and DMEM.
  - After the transfer with `d_cnt == n_d-1`, go to DRAIN.
- **DRAIN:** one cycle with `s_ready`=0, so the final write strobe completes. Then go to RUN.
- **RUN:** `cpu_enable`=1. `halt`=1 goes to IDLE.
- **ERROR:** `s_ready`=0 and no writes. Exit only by reset.
- **Write path:**
  - A transfer registers address and data; the strobe is high for exactly the next cycle.
  - The IMEM and DMEM strobes are never high in the same cycle.
  - Address outputs hold their last value when the strobe is low.
- **Ignored inputs:**
  - `start` outside IDLE is ignored.
  - `halt` outside RUN is ignored.
  - Stream words presented in IDLE, RUN or ERROR are not accepted.
- **Counters:** `i_cnt` is 9 bits plus overflow guard; `d_cnt` is 10 bits plus overflow guard. Both clear on entry to HEADER. A count equal to DEPTH is legal (fills memory exactly).

## Timing
- **Reset:** state IDLE. Every output is 0: addresses, data, strobes, `s_ready`, `cpu_enable`, `busy`, `done`, `error`, counters.
- **Reset mid-load:** the load aborts. Memory keeps a partial image, and `cpu_enable` stays 0.
- **`start` to `s_ready`:** `start` sampled at edge t gives `s_ready`=1 from cycle t+1.
- **Transfer to write strobe:** a transfer at edge t gives a strobe with address/data valid during cycle t+1, and the write occurs at edge t+2.
- **Throughput:** back-to-back transfers are allowed, one word per cycle with no bubbles, including across the LOAD_I→LOAD_D boundary.
- **End of load:** the last transfer at edge t gives DRAIN in cycle t+1 (last strobe high), then `cpu_enable`=1 and `done`=1 from cycle t+2.
- **Halt:** `halt` sampled at edge t gives `cpu_enable`=0 in cycle t+1. `start` may re-load from that cycle.

## Structure
- **Package `program_loader_pkg`:**
  - state enum `loader_state_t`;
  - header field positions (`HDR_NI_MSB`=31, `HDR_NI_LSB`=16, `HDR_ND_MSB`=15, `HDR_ND_LSB`=0);
  - byte-address shift constant `WORD_SHIFT`=2.
- **Sub-module `load_counter`:** parameterised width; clear/increment/terminal-count compare; instantiated twice (IMEM, DMEM).
- Everything else lives in `program_loader`.

## Test plan
- **Nominal load:** header `0x0003_0002`, IMEM words A0..A2, DMEM words D0..D1 back-to-back.
  - IMEM strobes at addresses 0x0, 0x4, 0x8, then DMEM strobes at 0x0, 0x4.
  - `cpu_enable`=1 two cycles after the last transfer.
- **Stalled stream:** same image with `s_valid` toggled 1/0.
  - Identical writes in the same order; exactly one strobe per accepted word.
- **Zero counts and full memory:**
  - Header `0x0000_0000` gives DRAIN then RUN with no strobes.
  - Header `0x0200_0000` writes 512 IMEM words, the last at 0x7FC.
- **Oversize header:** header `0x0201_0000` (513 words).
  - `error`=1 next cycle, `s_ready`=0, no strobes; `start` ignored until reset.
- **Reset mid-load:** `arst_n`=0 after 2 of 3 IMEM words.
  - All outputs 0 next cycle; a new `start` with header `0x0001_0000` loads correctly.
- **Halt and reload:**
  - `halt` in RUN gives `cpu_enable`=0 next cycle.
  - `start` and `halt` asserted in IDLE: `start` is honoured, `halt` is ignored.
